// File: rtl/bit_serial_pkg.sv
// Shared types for the serial front end and the pattern-detector benches.
package bit_serial_pkg;

  typedef enum logic [0:0] {
    SER_IDLE,
    SER_SHIFT
  } ser_state_e;

  localparam int unsigned DefaultWidth = 8;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word holding buffer for gapless streaming.
// bit_out/bit_valid/word_start are registered; data_ready depends only on state.
module bit_serializer
  import bit_serial_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             word_start,
  output logic             busy
);

  localparam int unsigned   CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_valid_q, hold_valid_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             word_start_q, word_start_d;

  logic             accept;
  logic             load_en;
  logic [WIDTH-1:0] load_word;

  assign data_ready = ~hold_valid_q;
  assign accept     = data_valid & ~hold_valid_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    bit_out_d    = bit_out_q;
    bit_valid_d  = bit_valid_q;
    word_start_d = 1'b0;
    load_en      = 1'b0;
    load_word    = data_in;

    unique case (state_q)
      SER_IDLE: begin
        bit_out_d   = IDLE_BIT;
        bit_valid_d = 1'b0;
        load_en     = accept;
      end
      SER_SHIFT: begin
        if (cnt_q != LastCnt) begin
          // shift_q holds only the bits not yet emitted, aligned to the output end
          bit_out_d = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
          shift_d   = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
          cnt_d     = cnt_q + CntW'(1);
          if (accept) begin
            hold_d       = data_in;
            hold_valid_d = 1'b1;
          end
        end else if (hold_valid_q) begin
          load_en      = 1'b1;
          load_word    = hold_q;
          hold_valid_d = accept;
          if (accept) begin
            hold_d = data_in;
          end
        end else if (accept) begin
          load_en = 1'b1;
        end else begin
          state_d     = SER_IDLE;
          bit_out_d   = IDLE_BIT;
          bit_valid_d = 1'b0;
        end
      end
      default: state_d = SER_IDLE;
    endcase

    if (load_en) begin
      state_d      = SER_SHIFT;
      cnt_d        = '0;
      bit_valid_d  = 1'b1;
      word_start_d = 1'b1;
      bit_out_d    = MSB_FIRST ? load_word[WIDTH-1] : load_word[0];
      shift_d      = MSB_FIRST ? (load_word << 1) : (load_word >> 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= SER_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      bit_out_q    <= IDLE_BIT;
      bit_valid_q  <= 1'b0;
      word_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
      word_start_q <= word_start_d;
    end
  end

  assign bit_out    = bit_out_q;
  assign bit_valid  = bit_valid_q;
  assign word_start = word_start_q;
  assign busy       = (state_q == SER_SHIFT) | hold_valid_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: MSB-first and LSB-first instances, reset abort,
// and a toggling-valid run checked against a queue of accepted words.
module tb_bit_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] m_din, l_din;
  logic       m_dv, l_dv;
  logic       m_rdy, m_bit, m_bv, m_ws, m_busy;
  logic       l_rdy, l_bit, l_bv, l_ws, l_busy;

  int checks;
  int failures;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk        (clk),
    .rst        (rst),
    .data_in    (m_din),
    .data_valid (m_dv),
    .data_ready (m_rdy),
    .bit_out    (m_bit),
    .bit_valid  (m_bv),
    .word_start (m_ws),
    .busy       (m_busy)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk        (clk),
    .rst        (rst),
    .data_in    (l_din),
    .data_valid (l_dv),
    .data_ready (l_rdy),
    .bit_out    (l_bit),
    .bit_valid  (l_bv),
    .word_start (l_ws),
    .busy       (l_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0]  w8;
  logic [23:0] stream;
  logic [7:0]  q[$];
  logic [7:0]  cur;
  int          nbits;
  int          words;
  logic [7:0]  got;

  initial begin
    checks   = 0;
    failures = 0;
    rst   = 1'b1;
    m_dv  = 1'b0; m_din = '0;
    l_dv  = 1'b0; l_din = '0;

    // Reset state
    @(negedge clk);
    chk("rst_bit_out", m_bit, 0);
    chk("rst_bit_valid", m_bv, 0);
    chk("rst_word_start", m_ws, 0);
    chk("rst_busy", m_busy, 0);
    chk("rst_ready", m_rdy, 1);
    rst = 1'b0;
    @(negedge clk);

    // Single word 0xCC MSB-first from idle
    w8 = 8'hCC;
    m_din = w8; m_dv = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      m_dv = 1'b0;
      chk($sformatf("cc_bit%0d", i), m_bit, w8[7-i]);
      chk($sformatf("cc_bv%0d", i), m_bv, 1);
      chk($sformatf("cc_ws%0d", i), m_ws, (i == 0) ? 1 : 0);
    end
    @(negedge clk);
    chk("cc_idle_bit", m_bit, 0);
    chk("cc_idle_bv", m_bv, 0);
    chk("cc_idle_busy", m_busy, 0);

    // Back-to-back C0, 3F with A5 offered while hold is full
    stream = 24'hC03FA5;
    m_din = 8'hC0; m_dv = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      chk($sformatf("b2b_bit%0d", i), m_bit, stream[23-i]);
      chk($sformatf("b2b_bv%0d", i), m_bv, 1);
      chk($sformatf("b2b_ws%0d", i), m_ws, (i % 8 == 0) ? 1 : 0);
      chk($sformatf("b2b_busy%0d", i), m_busy, 1);
      if (i == 0) begin
        chk("b2b_ready0", m_rdy, 1);
        m_din = 8'h3F;
      end else if (i == 1) begin
        m_din = 8'hA5;
      end
      if (i >= 1 && i <= 7) chk($sformatf("b2b_ready%0d", i), m_rdy, 0);
      if (i == 8) chk("b2b_ready8", m_rdy, 1);
      if (i == 9) m_dv = 1'b0;
    end
    @(negedge clk);
    chk("b2b_idle_bv", m_bv, 0);
    chk("b2b_idle_bit", m_bit, 0);
    chk("b2b_idle_busy", m_busy, 0);

    // LSB-first instance, 0x03
    w8 = 8'h03;
    l_din = w8; l_dv = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      l_dv = 1'b0;
      chk($sformatf("lsb_bit%0d", i), l_bit, w8[i]);
      chk($sformatf("lsb_bv%0d", i), l_bv, 1);
      chk($sformatf("lsb_ws%0d", i), l_ws, (i == 0) ? 1 : 0);
    end
    @(negedge clk);
    chk("lsb_idle_bv", l_bv, 0);

    // Reset on 4th bit of 0xCC with 0x55 held
    m_din = 8'hCC; m_dv = 1'b1;
    @(negedge clk);
    m_din = 8'h55;
    @(negedge clk);
    m_dv = 1'b0;
    chk("abort_ready_held", m_rdy, 0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_bv_before", m_bv, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_bit", m_bit, 0);
    chk("abort_bv", m_bv, 0);
    chk("abort_ws", m_ws, 0);
    chk("abort_busy", m_busy, 0);
    chk("abort_ready", m_rdy, 1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_bit%0d", i), m_bit, 0);
      chk($sformatf("post_rst_bv%0d", i), m_bv, 0);
    end
    chk("post_rst_ready", m_rdy, 1);

    // Toggling valid with random data, checked against accepted-word queue
    cur = '0; nbits = 0; words = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (m_bv) begin
        if (m_ws) begin
          if (nbits != 0) chk("rand_partial_word", nbits, 0);
          nbits = 0;
        end
        cur = {cur[6:0], m_bit};
        nbits++;
        if (nbits == 8) begin
          if (q.size() == 0) begin
            chk("rand_unexpected_word", 1, 0);
          end else begin
            got = q.pop_front();
            chk($sformatf("rand_word%0d", words), cur, got);
          end
          words++;
          nbits = 0;
        end
      end
      if (c < 90) begin
        m_dv  = c[0];
        m_din = 8'($urandom);
        if (m_dv && m_rdy) q.push_back(m_din);
      end else begin
        m_dv = 1'b0;
      end
    end
    chk("rand_queue_drained", q.size(), 0);
    chk("rand_words_seen_gt8", (words > 8) ? 1 : 0, 1);
    chk("rand_final_busy", m_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
